// File: rtl/mem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_sram_ctrl
//   MEM-stage data-memory initiator. Each 32-bit load or store from the
//   EXE/MEM register is split into two 16-bit half-word accesses on an
//   external SRAM: the low half first, then the high half. Each half is held
//   on the pins for ACCESS_CYCLES cycles. While an access is in flight,
//   ready is low so the hazard logic can freeze the pipeline.
//
// Ports
//   clk, rst        pipeline clock, asynchronous active-high reset
//   wr_en, rd_en    store / load request (a store wins if both are set)
//   address         CPU byte address (word aligned; bits [1:0] ignored)
//   write_data      store value
//   read_data       last completed load word (registered)
//   ready           0 while an access is in flight
//   sram_addr       SRAM half-word address
//   sram_dq_out     write data to the SRAM pad
//   sram_dq_oe      1 when the controller drives the data pad
//   sram_dq_in      read data from the SRAM pad
//   sram_we_n       SRAM write strobe, active low
// ---------------------------------------------------------------------------
module mem_sram_ctrl #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 2,
    parameter int SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_is_wr;
    logic [SRAM_AW-2:0]   r_hw;
    logic [15:0]          r_wdata_hi;
    logic [15:0]          r_lo;
    logic [31:0]          r_read_data;
    logic [SRAM_AW-1:0]   r_sram_addr;
    logic [15:0]          r_dq_out;
    logic                 r_dq_oe;
    logic                 r_we_n;

    state_t               w_nxt_state;
    logic [CW-1:0]        w_nxt_cnt;
    logic [SRAM_AW-1:0]   w_nxt_addr;
    logic [15:0]          w_nxt_dq_out;
    logic                 w_nxt_dq_oe;
    logic                 w_nxt_we_n;
    logic                 w_ready;
    logic                 w_capture;
    logic                 w_latch_lo;
    logic                 w_latch_hi;
    logic                 w_req;
    logic [31:0]          w_off;
    logic [SRAM_AW-2:0]   w_req_hw;
    logic                 w_unused_off;

    // Offset from the SRAM window; wraps modulo 2^32 below BASE_ADDR.
    assign w_off        = address - 32'(BASE_ADDR);
    assign w_req_hw     = w_off[SRAM_AW:2];
    assign w_unused_off = ^{w_off[31:SRAM_AW+1], w_off[1:0]};
    assign w_req        = wr_en | rd_en;

    // Next state and next pin values; pins are registered so they change
    // on the same edge that enters LO/HI/DONE.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_addr   = r_sram_addr;
        w_nxt_dq_out = r_dq_out;
        w_nxt_dq_oe  = r_dq_oe;
        w_nxt_we_n   = r_we_n;
        w_ready      = 1'b1;
        w_capture    = 1'b0;
        w_latch_lo   = 1'b0;
        w_latch_hi   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = ~w_req;
                if (w_req) begin
                    w_nxt_state = S_LO;
                    w_nxt_cnt   = '0;
                    w_capture   = 1'b1;
                    w_nxt_addr  = {w_req_hw, 1'b0};
                    if (wr_en) begin
                        w_nxt_dq_out = write_data[15:0];
                        w_nxt_dq_oe  = 1'b1;
                        w_nxt_we_n   = 1'b0;
                    end else begin
                        w_nxt_dq_oe  = 1'b0;
                        w_nxt_we_n   = 1'b1;
                    end
                end else begin
                    w_nxt_dq_oe = 1'b0;
                    w_nxt_we_n  = 1'b1;
                end
            end
            S_LO: begin
                w_ready = 1'b0;
                if (r_cnt == LAST_CNT) begin
                    w_nxt_state = S_HI;
                    w_nxt_cnt   = '0;
                    w_latch_lo  = ~r_is_wr;
                    w_nxt_addr  = {r_hw, 1'b1};
                    if (r_is_wr) begin
                        w_nxt_dq_out = r_wdata_hi;
                        w_nxt_dq_oe  = 1'b1;
                        w_nxt_we_n   = 1'b0;
                    end else begin
                        w_nxt_dq_oe  = 1'b0;
                        w_nxt_we_n   = 1'b1;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            S_HI: begin
                w_ready = 1'b0;
                if (r_cnt == LAST_CNT) begin
                    w_nxt_state = S_DONE;
                    w_nxt_cnt   = '0;
                    w_latch_hi  = ~r_is_wr;
                    w_nxt_dq_oe = 1'b0;
                    w_nxt_we_n  = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                // The pipeline advances on this edge; the next request is
                // evaluated only in the following IDLE cycle.
                w_ready     = 1'b1;
                w_nxt_state = S_IDLE;
                w_nxt_dq_oe = 1'b0;
                w_nxt_we_n  = 1'b1;
            end
            default: begin
                w_ready     = 1'b1;
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
                w_nxt_dq_oe = 1'b0;
                w_nxt_we_n  = 1'b1;
            end
        endcase
    end

    // State, counter and SRAM pin registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= 16'h0000;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_sram_addr <= w_nxt_addr;
            r_dq_out    <= w_nxt_dq_out;
            r_dq_oe     <= w_nxt_dq_oe;
            r_we_n      <= w_nxt_we_n;
        end
    end

    // Captured request copy, so mid-access input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_wr    <= 1'b0;
            r_hw       <= '0;
            r_wdata_hi <= 16'h0000;
        end else if (w_capture) begin
            r_is_wr    <= wr_en;
            r_hw       <= w_req_hw;
            r_wdata_hi <= write_data[31:16];
        end
    end

    // Load data: low half held until the high half completes the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo        <= 16'h0000;
            r_read_data <= 32'h0000_0000;
        end else begin
            if (w_latch_lo) begin
                r_lo <= sram_dq_in;
            end
            if (w_latch_hi) begin
                r_read_data <= {sram_dq_in, r_lo};
            end
        end
    end

    assign read_data   = r_read_data;
    assign ready       = w_ready;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- Data-memory initiator for the MEM stage. Takes one load or store per instruction from the EXE/MEM pipeline register and performs it as two 16-bit half-word accesses on the external SRAM.
- Returns the 32-bit load word to the MEM/WB register's data-memory input.
- Drives `ready` low while an access is in flight; the hazard/freeze logic uses `~ready` to stall all pipeline registers.

Parameters:
- BASE_ADDR, 1024: CPU byte address that maps to SRAM word 0.
- ACCESS_CYCLES, 2: clock cycles each half-word access is held on the SRAM pins (>=1).
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  store request (MEM write enable from EXE/MEM reg)
- rd_en  in  1  load request (MEM read enable from EXE/MEM reg)
- address  in  32  CPU byte address (ALU result); word-aligned
- write_data  in  32  store value
- read_data  out  32  load result, to MEM/WB data-memory input
- ready  out  1  0 = access in flight, pipeline must freeze
- sram_addr  out  SRAM_AW  SRAM half-word address
- sram_dq_out  out  16  write data to SRAM pad
- sram_dq_oe  out  1  1 = controller drives the data pad
- sram_dq_in  in  16  read data from SRAM pad
- sram_we_n  out  1  SRAM write strobe, active low

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address mapping:
  - off = address - BASE_ADDR, computed in 32 bits.
  - Wrap below BASE_ADDR is modulo 2^32; no error is flagged.
  - Low half uses sram_addr = {off[SRAM_AW:2], 1'b0}; high half uses {off[SRAM_AW:2], 1'b1}.
  - off[1:0] is ignored.
- Request decode:
  - The request is sampled in IDLE.
  - wr_en has priority: wr_en=1 with rd_en=1 is treated as a store only.
  - wr_en=rd_en=0 means no access; the controller stays in IDLE.
- States:
  - IDLE:
    - ready = ~(wr_en | rd_en), combinational.
    - On a request, capture address, write_data and op; go to LO with counter=0.
  - LO:
    - Drive the low-half address.
    - Store: sram_dq_out = wdata[15:0], sram_dq_oe=1, sram_we_n=0.
    - Load: sram_dq_oe=0, sram_we_n=1.
    - Stay ACCESS_CYCLES cycles. On the last cycle a load latches sram_dq_in into lo_reg. Then go to HI.
  - HI:
    - Same as LO with the high-half address and wdata[31:16].
    - On the last cycle a load latches sram_dq_in into hi_reg. Then go to DONE.
  - DONE:
    - ready=1. For a load, read_data = {hi_reg, lo_reg}, registered and updated on entry to DONE.
    - sram_we_n=1, sram_dq_oe=0.
    - Unconditionally return to IDLE next cycle.
- ready is 0 in LO and HI.
- Latency: a request first visible in IDLE at cycle t gives ready=1 at cycle t+2*ACCESS_CYCLES+1 (t+5 at default).
- The pipeline advances on the DONE edge, and the next instruction's request is evaluated in the following IDLE cycle. There is never back-to-back DONE→LO without an IDLE cycle.
- read_data holds its value until the next load completes; stores do not change it.
- sram_we_n is never 0 outside LO/HI of a store. sram_we_n=1 whenever sram_dq_oe=0.
- Requests changing mid-access are ignored because the captured copy is used. This is legal since the pipeline is frozen.
- rst asserted mid-access: abort immediately to the reset state. A partially written word is left as-is in SRAM.

Test Plan:
- Reset: hold rst with a store pending → sram_we_n=1, sram_dq_oe=0, ready=1 in IDLE with no request, read_data=0.
- Store: wr_en=1, address=1032, write_data=0xDEADBEEF, ACCESS_CYCLES=2.
  - Cycles t+1..t+2: sram_addr=4, dq_out=0xBEEF, we_n=0.
  - Cycles t+3..t+4: sram_addr=5, dq_out=0xDEAD.
  - ready=0 for t..t+4 and =1 at t+5.
- Load: SRAM model with [4]=0xBEEF, [5]=0xDEAD; rd_en=1, address=1032 → read_data=0xDEADBEEF at t+5, dq_oe=0 and we_n=1 throughout.
- Priority: wr_en=rd_en=1, address=1024, write_data=0x12345678 → store to sram_addr 0/1 (0x5678/0x1234); read_data unchanged.
- Back-to-back load then store: second request starts one IDLE cycle after DONE; read_data keeps the load value through the store.
- Mid-access reset: assert rst at t+3 of a store → outputs at reset values that same cycle; next request restarts from LO with correct timing.
